pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Drives stall (hold) and flush (bubble) controls into the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Sources of control: load-use hazards, taken branches/jumps resolved in EX, and a multi-cycle data-memory handshake in MEM.
- The memory handshake is tracked by a wait FSM with timeout, error latch and a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 16, max consecutive wait cycles on a data-memory access before the error state is entered (range 1..255).
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemRead_EX  input  1  instruction in EX is a load.
- RD_ID_EX  input  5  destination register of the instruction in EX.
- RS1_IF_ID  input  5  rs1 of the instruction in ID.
- RS2_IF_ID  input  5  rs2 of the instruction in ID.
- Branch_taken_EX  input  1  branch/jump in EX redirects the PC.
- mem_req_MEM  input  1  MEM-stage instruction accesses data memory (load or store).
- dmem_ready  input  1  data memory completes the access this cycle.
- err_clear  input  1  clears the sticky memory error.
- PCWrite  output  1  PC update enable.
- IF_ID_write  output  1  IF/ID load enable.
- IF_ID_flush  output  1  IF/ID loads a bubble.
- ID_EX_flush  output  1  ID/EX control bits zeroed.
- EX_MEM_write  output  1  EX/MEM load enable.
- MEM_WB_flush  output  1  MEM/WB RegWrite/MemtoReg forced to 0.
- mem_error  output  1  sticky data-memory timeout flag.
- stall_cycles  output  PERF_W  saturating count of cycles with PCWrite=0.

Behaviour:
- FSM states: IDLE, WAIT, ERROR; registered; reset value IDLE.
- Wait counter: 8-bit, reset value 0.
- mem_error: reset value 0. stall_cycles: reset value 0.
- While reset is low, all combinational outputs are driven inactive: PCWrite=1, IF_ID_write=1, EX_MEM_write=1, all flushes 0.
- mem_stall = (state==IDLE & mem_req_MEM & ~dmem_ready) | (state==WAIT & ~dmem_ready) | (state==ERROR). Combinational, zero-cycle latency.
- load_use = MemRead_EX & (RD_ID_EX!=0) & (RD_ID_EX==RS1_IF_ID | RD_ID_EX==RS2_IF_ID).
- Output priority:
  1. mem_stall: PCWrite=0, IF_ID_write=0, EX_MEM_write=0, MEM_WB_flush=1, IF_ID_flush=0, ID_EX_flush=0. The pipeline is frozen; branch/load-use actions are deferred and re-evaluated once the freeze lifts, because EX inputs are held.
  2. Branch_taken_EX: IF_ID_flush=1, ID_EX_flush=1, PCWrite=1, IF_ID_write=1. Load-use is ignored because the ID instruction is squashed.
  3. load_use: PCWrite=0, IF_ID_write=0, ID_EX_flush=1. One bubble per hazard, because the load advances to MEM next cycle.
  4. Otherwise: all writes 1, all flushes 0.
- Transitions:
  - IDLE -> WAIT when mem_req_MEM & ~dmem_ready; counter loads 1.
  - IDLE stays IDLE otherwise, including a single-cycle access with mem_req_MEM & dmem_ready.
  - WAIT -> IDLE when dmem_ready; counter cleared. The stall drops in that same cycle.
  - WAIT stays WAIT while ~dmem_ready, counter increments. When counter==MEM_TIMEOUT & ~dmem_ready: -> ERROR, mem_error set next edge.
  - ERROR holds the full freeze regardless of dmem_ready.
  - ERROR -> IDLE on err_clear: counter=0, mem_error=0 at the same edge.
  - err_clear in IDLE/WAIT has no effect.
- stall_cycles increments on every edge where PCWrite=0 and saturates at all-ones. It does not wrap.
- Reset asserted mid-WAIT or in ERROR returns to IDLE immediately (asynchronous) and clears the counter, mem_error and stall_cycles.
- Timeout boundary: with MEM_TIMEOUT=N, dmem_ready arriving in the N-th wait cycle completes normally; it wins over the timeout.

Test Plan:
- Load-use: MemRead_EX=1, RD_ID_EX=5, RS2_IF_ID=5 for one cycle -> PCWrite=0, IF_ID_write=0, ID_EX_flush=1 that cycle; stall_cycles 0->1. Repeat with RD_ID_EX=0 -> no stall.
- Branch + load-use same cycle: Branch_taken_EX=1, load-use true -> IF_ID_flush=1, ID_EX_flush=1, PCWrite=1, stall_cycles unchanged.
- Memory wait: mem_req_MEM=1, dmem_ready low 3 cycles then high -> freeze (PCWrite=0, MEM_WB_flush=1) exactly 3 cycles, state IDLE after, stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready held low -> ERROR entered after 4 WAIT cycles, mem_error=1; later dmem_ready=1 keeps freeze; err_clear pulse -> IDLE, mem_error=0.
- Boundary: MEM_TIMEOUT=4, dmem_ready rises on 4th wait cycle -> no error, back to IDLE.
- Async reset: drive reset low mid-WAIT (no clock edge) -> outputs immediately PCWrite=1, all flushes 0, mem_error=0, stall_cycles=0. Also force stall_cycles to saturation with PERF_W=4 -> holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken-branch and
// data-memory wait handling with timeout error latch and stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead_EX,
    input  logic [4:0]        RD_ID_EX,
    input  logic [4:0]        RS1_IF_ID,
    input  logic [4:0]        RS2_IF_ID,
    input  logic              Branch_taken_EX,
    input  logic              mem_req_MEM,
    input  logic              dmem_ready,
    input  logic              err_clear,
    output logic              PCWrite,
    output logic              IF_ID_write,
    output logic              IF_ID_flush,
    output logic              ID_EX_flush,
    output logic              EX_MEM_write,
    output logic              MEM_WB_flush,
    output logic              mem_error,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state, state_next;
    logic [7:0] wait_cnt, wait_cnt_next;
    logic       mem_error_next;
    logic       mem_stall;
    logic       load_use;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            mem_error <= mem_error_next;
        end
    end

    always_comb begin
        state_next     = state;
        wait_cnt_next  = wait_cnt;
        mem_error_next = mem_error;
        case (state)
            IDLE: begin
                if (mem_req_MEM && !dmem_ready) begin
                    state_next    = WAIT;
                    wait_cnt_next = 8'd1;
                end
            end
            WAIT: begin
                // ready in the final allowed cycle still completes normally
                if (dmem_ready) begin
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    state_next     = ERROR;
                    mem_error_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            ERROR: begin
                if (err_clear) begin
                    state_next     = IDLE;
                    wait_cnt_next  = '0;
                    mem_error_next = 1'b0;
                end
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    assign mem_stall = (state == IDLE && mem_req_MEM && !dmem_ready) ||
                       (state == WAIT && !dmem_ready) ||
                       (state == ERROR);

    assign load_use = MemRead_EX && (RD_ID_EX != 5'd0) &&
                      ((RD_ID_EX == RS1_IF_ID) || (RD_ID_EX == RS2_IF_ID));

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_write = 1'b1;
        MEM_WB_flush = 1'b0;
        if (reset) begin
            if (mem_stall) begin
                PCWrite      = 1'b0;
                IF_ID_write  = 1'b0;
                EX_MEM_write = 1'b0;
                MEM_WB_flush = 1'b1;
            end else if (Branch_taken_EX) begin
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
            end else if (load_use) begin
                PCWrite     = 1'b0;
                IF_ID_write = 1'b0;
                ID_EX_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (!PCWrite && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed scoreboard bench for pipeline_hazard_ctrl; two
// instances share stimulus so the 4-bit stall counter saturation is also covered.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead_EX = 1'b0;
    logic [4:0]  RD_ID_EX = '0, RS1_IF_ID = '0, RS2_IF_ID = '0;
    logic        Branch_taken_EX = 1'b0, mem_req_MEM = 1'b0, dmem_ready = 1'b0, err_clear = 1'b0;

    logic        pc_a, ifidw_a, ifidf_a, idexf_a, exmemw_a, memwbf_a, merr_a;
    logic        pc_b, ifidw_b, ifidf_b, idexf_b, exmemw_b, memwbf_b, merr_b;
    logic [15:0] st_a;
    logic [3:0]  st_b;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .PERF_W(16)) dut_a (
        .clk(clk), .reset(reset), .MemRead_EX(MemRead_EX), .RD_ID_EX(RD_ID_EX),
        .RS1_IF_ID(RS1_IF_ID), .RS2_IF_ID(RS2_IF_ID), .Branch_taken_EX(Branch_taken_EX),
        .mem_req_MEM(mem_req_MEM), .dmem_ready(dmem_ready), .err_clear(err_clear),
        .PCWrite(pc_a), .IF_ID_write(ifidw_a), .IF_ID_flush(ifidf_a), .ID_EX_flush(idexf_a),
        .EX_MEM_write(exmemw_a), .MEM_WB_flush(memwbf_a), .mem_error(merr_a), .stall_cycles(st_a)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .PERF_W(4)) dut_b (
        .clk(clk), .reset(reset), .MemRead_EX(MemRead_EX), .RD_ID_EX(RD_ID_EX),
        .RS1_IF_ID(RS1_IF_ID), .RS2_IF_ID(RS2_IF_ID), .Branch_taken_EX(Branch_taken_EX),
        .mem_req_MEM(mem_req_MEM), .dmem_ready(dmem_ready), .err_clear(err_clear),
        .PCWrite(pc_b), .IF_ID_write(ifidw_b), .IF_ID_flush(ifidf_b), .ID_EX_flush(idexf_b),
        .EX_MEM_write(exmemw_b), .MEM_WB_flush(memwbf_b), .mem_error(merr_b), .stall_cycles(st_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pc, ifidw, ifidf, idexf, exmemw, memwbf, merr;
        logic [15:0] st16;
        logic [3:0]  st4;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: length of the current outstanding access and error flag
    int   pending = 0;
    bit   err = 0;
    int   stall16 = 0;
    int   stall4 = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("PCWrite_a", pc_a, e.pc);
            chk("IF_ID_write_a", ifidw_a, e.ifidw);
            chk("IF_ID_flush_a", ifidf_a, e.ifidf);
            chk("ID_EX_flush_a", idexf_a, e.idexf);
            chk("EX_MEM_write_a", exmemw_a, e.exmemw);
            chk("MEM_WB_flush_a", memwbf_a, e.memwbf);
            chk("mem_error_a", merr_a, e.merr);
            chk("stall_cycles_a", st_a, e.st16);
            chk("PCWrite_b", pc_b, e.pc);
            chk("ID_EX_flush_b", idexf_b, e.idexf);
            chk("MEM_WB_flush_b", memwbf_b, e.memwbf);
            chk("mem_error_b", merr_b, e.merr);
            chk("stall_cycles_b", st_b, e.st4);
        end
    end

    task automatic cyc(input bit r, input bit mr, input int rd, input int rs1, input int rs2,
                       input bit br, input bit req, input bit rdy, input bit clr);
        exp_t e;
        bit   freeze, lu;
        @(posedge clk);
        #1;
        reset = r; MemRead_EX = mr; RD_ID_EX = 5'(rd); RS1_IF_ID = 5'(rs1); RS2_IF_ID = 5'(rs2);
        Branch_taken_EX = br; mem_req_MEM = req; dmem_ready = rdy; err_clear = clr;

        freeze = err || ((pending > 0 || req) && !rdy);
        lu = mr && rd != 0 && (rd == rs1 || rd == rs2);
        e = '{pc: 1'b1, ifidw: 1'b1, ifidf: 1'b0, idexf: 1'b0, exmemw: 1'b1, memwbf: 1'b0,
              merr: err, st16: 16'(stall16), st4: 4'(stall4)};
        if (r) begin
            if (freeze) begin
                e.pc = 0; e.ifidw = 0; e.exmemw = 0; e.memwbf = 1;
            end else if (br) begin
                e.ifidf = 1; e.idexf = 1;
            end else if (lu) begin
                e.pc = 0; e.ifidw = 0; e.idexf = 1;
            end
        end else begin
            e.merr = 0; e.st16 = 0; e.st4 = 0;
        end
        sb.push_back(e);

        if (!r) begin
            pending = 0; err = 0; stall16 = 0; stall4 = 0;
        end else begin
            if (!e.pc) begin
                if (stall16 < 65535) stall16++;
                if (stall4 < 15) stall4++;
            end
            if (err) begin
                if (clr) err = 0;
                pending = 0;
            end else if (freeze) begin
                if (pending == TO) begin
                    err = 1; pending = 0;
                end else begin
                    pending++;
                end
            end else begin
                pending = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 5, 0, 5, 0, 1, 0, 0);
        idle(1);
        // load-use, then rd=0 gives no stall
        cyc(1, 1, 5, 0, 5, 0, 0, 0, 0);
        idle(1);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        // branch overrides load-use
        cyc(1, 1, 7, 7, 3, 1, 0, 0, 0);
        // three-cycle memory wait
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
        idle(1);
        // timeout into ERROR, ready ignored, err_clear recovers
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 1, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(2);
        // ready on the last allowed wait cycle completes normally
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
        idle(1);
        // err_clear while waiting has no effect
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        // reset asserted mid-wait between edges
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        // drive the 4-bit counter into saturation
        for (int i = 0; i < 20; i++) cyc(1, 1, 9, 9, 1, 0, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 2000; i++) begin
            int rd, rs1, rs2;
            bit r;
            rd = $urandom_range(0, 3); rs1 = $urandom_range(0, 3); rs2 = $urandom_range(0, 3);
            r = ($urandom_range(0, 199) != 0);
            cyc(r, $urandom_range(0, 1) == 1, rd, rs1, rs2, $urandom_range(0, 5) == 0,
                $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4, $urandom_range(0, 7) == 0);
        end
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
